// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the 8N1 UART receiver.
//   - FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH)
//   - frame shape (8 data bits, 1 stop bit)
//   - helpers deriving the per-symbol and mid-symbol cycle counts
package uart_pkg;

  localparam int unsigned DataBits = 8;
  localparam int unsigned StopBits = 1;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StStop     = 3'd3;
  localparam logic [2:0] StWaitHigh = 3'd4;

  // Clock cycles per bit on the line (integer division).
  function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Cycles from the start edge to the middle of the start bit.
  function automatic int unsigned sample_time(input int unsigned symbol_time);
    return symbol_time / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so a reset never looks like a start bit.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   serial_i - raw line input
//   rx_o     - synchronized line
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic serial_i,
  output logic rx_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], serial_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_o = sync_q[1];

endmodule

// File: rtl/uart_frame_receiver.sv
// uart_frame_receiver: 8N1 UART receiver with a one-entry ready/valid output buffer.
// Samples each bit mid-period, checks start and stop bits, and reports framing errors
// and overruns as one-cycle pulses.
// Optional feature: define UART_RX_SYNC_EN to put a two-flop synchronizer in front of
// the FSM (adds 2 cycles of latency); otherwise serial_in is used directly.
// Ports:
//   clk            - sole clock, rising edge
//   rst            - asynchronous active-high reset
//   serial_in      - UART line, idles high
//   data_out       - received byte, LSB first on the line
//   data_out_valid - data_out holds an unconsumed byte
//   data_out_ready - consumer accepts when valid and ready are high on an edge
//   framing_error  - one-cycle pulse, stop bit sampled low
//   overrun        - one-cycle pulse, good byte dropped because the buffer was full
module uart_frame_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int unsigned SymbolEdgeTime = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned SampleTime     = sample_time(SymbolEdgeTime);
  localparam int unsigned CntW           = $clog2(SymbolEdgeTime);

  localparam logic [CntW-1:0] SymbolLast = CntW'(SymbolEdgeTime - 1);
  localparam logic [CntW-1:0] SampleLast = CntW'(SampleTime - 1);
  localparam logic [2:0]      BitLast    = 3'(DataBits - 1);

  if (SymbolEdgeTime < 4 || StopBits != 1) begin : g_bad_cfg
    $error("uart_frame_receiver: need >= 4 clocks per bit and one stop bit");
  end

  logic rx;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_rx_sync (
    .clk      (clk),
    .rst      (rst),
    .serial_i (serial_in),
    .rx_o     (rx)
  );
`else
  assign rx = serial_in;
`endif

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            framing_error_q, framing_error_d;
  logic            overrun_q, overrun_d;
  logic            commit;
  logic            handshake;

  // Frame FSM: counters, shift register and stop-bit verdict.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_d           = bit_q;
    shift_d         = shift_q;
    commit          = 1'b0;
    framing_error_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == SampleLast) begin
          if (!rx) begin
            state_d = StData;
            cnt_d   = '0;
            bit_d   = '0;
          end else begin
            // Line went back high before mid-bit: a glitch, not a start bit.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == SymbolLast) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          if (bit_q == BitLast) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == SymbolLast) begin
          cnt_d = '0;
          if (rx) begin
            commit  = 1'b1;
            state_d = StIdle;
          end else begin
            framing_error_d = 1'b1;
            state_d         = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitHigh: begin
        // Hold off until the line recovers so a break is not read as a start bit.
        if (rx) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // One-entry output buffer.
  assign handshake = valid_q & data_out_ready;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (handshake) begin
      valid_d = 1'b0;
    end
    if (commit) begin
      // A slot freed by this cycle's handshake can take the new byte immediately.
      if (!valid_q || handshake) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_q           <= bit_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      valid_q         <= valid_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = framing_error_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Self-checking bench for uart_frame_receiver at 50 MHz / 1 Mbaud (50 cycles per bit).
// The line is driven synchronously, so the default (unsynchronized) build is used.
module tb_uart_frame_receiver;

  localparam int unsigned ClockFreq = 50_000_000;
  localparam int unsigned BaudRate  = 1_000_000;
  localparam int BitCycles = ClockFreq / BaudRate;
  // Line driven low just after edge T is first read at edge T+1; the byte is committed
  // half a bit plus nine full bits later.
  localparam int CommitOffset = 1 + BitCycles / 2 + 9 * BitCycles;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       data_out_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       framing_error;
  logic       overrun;

  uart_frame_receiver #(
    .CLOCK_FREQ (ClockFreq),
    .BAUD_RATE  (BaudRate)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled on the falling edge.
  logic [7:0] acc_q[$];     // bytes accepted by handshake
  int         rise_q[$];    // cycle at which valid rose
  int         fe_cyc_q[$];  // cycle of each framing_error-high cycle
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         valid_cycles = 0;
  logic       valid_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_out_valid && data_out_ready) acc_q.push_back(data_out);
      if (data_out_valid && !valid_prev) rise_q.push_back(cyc);
      if (framing_error) fe_cyc_q.push_back(cyc);
      if (data_out_valid) valid_cycles <= valid_cycles + 1;
      if (framing_error) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
    end
    valid_prev <= data_out_valid;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic drive_bits(input logic v, input int nbits);
    serial_in = v;
    repeat (nbits * BitCycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low_bits, output int start_cyc);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(b[i], 1);
    if (stop_low_bits > 0) drive_bits(1'b0, stop_low_bits);
    drive_bits(1'b1, 1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 8'h00) begin
      n_errors++; $display("FAIL reset_data: got %h want 00", data_out);
    end
    n_checks++;
    if (data_out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b want 0", data_out_valid);
    end
    n_checks++;
    if (framing_error !== 1'b0 || overrun !== 1'b0) begin
      n_errors++; $display("FAIL reset_pulses: got fe=%b ov=%b want 0 0", framing_error, overrun);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int t;
    int acc_base = acc_q.size();
    int rise_base = rise_q.size();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    int v0 = valid_cycles;
    data_out_ready = 1'b1;
    send_frame(8'h61, 0, t);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (acc_q.size() - acc_base !== 1) begin
      n_errors++; $display("FAIL single_count: got %0d bytes want 1", acc_q.size() - acc_base);
    end else begin
      n_checks++;
      if (acc_q[acc_base] !== 8'h61) begin
        n_errors++; $display("FAIL single_data: got %h want 61", acc_q[acc_base]);
      end
    end
    n_checks++;
    if (rise_q.size() <= rise_base || rise_q[rise_base] !== t + CommitOffset) begin
      n_errors++;
      $display("FAIL single_latency: got %0d want %0d",
               (rise_q.size() > rise_base) ? rise_q[rise_base] - t : -1, CommitOffset);
    end
    n_checks++;
    if (valid_cycles - v0 !== 1) begin
      n_errors++; $display("FAIL single_valid_width: got %0d want 1", valid_cycles - v0);
    end
    n_checks++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      n_errors++; $display("FAIL single_pulses: got fe=%0d ov=%0d want 0 0",
                           fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'h61, 8'h62, 8'h63};
    int t;
    int acc_base = acc_q.size();
    int ov0 = ov_cnt;
    data_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 0, t);
    repeat (5) @(posedge clk);
    #1;
    // Buffer keeps the first byte; every later one is an overrun.
    n_checks++;
    if (data_out_valid !== 1'b1 || data_out !== bytes[0]) begin
      n_errors++; $display("FAIL b2b_hold: got v=%b d=%h want v=1 d=%h",
                           data_out_valid, data_out, bytes[0]);
    end
    n_checks++;
    if (ov_cnt - ov0 !== 2) begin
      n_errors++; $display("FAIL b2b_overrun: got %0d want 2", ov_cnt - ov0);
    end
    data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    data_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (data_out_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_drain_valid: got %b want 0", data_out_valid);
    end
    n_checks++;
    if (acc_q.size() - acc_base !== 1 || acc_q[acc_base] !== bytes[0]) begin
      n_errors++; $display("FAIL b2b_accepted: got %0d bytes want 1 of %h",
                           acc_q.size() - acc_base, bytes[0]);
    end
  endtask

  task automatic test_glitch();
    int t;
    int acc_base = acc_q.size();
    int rise_base = rise_q.size();
    int fe0 = fe_cnt;
    data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    serial_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (2 * BitCycles) @(posedge clk);
    #1;
    n_checks++;
    if (acc_q.size() != acc_base || rise_q.size() != rise_base || fe_cnt != fe0) begin
      n_errors++; $display("FAIL glitch_quiet: got bytes=%0d fe=%0d want 0 0",
                           rise_q.size() - rise_base, fe_cnt - fe0);
    end
    // A clean frame right after must arrive with normal latency (FSM is idle).
    send_frame(8'ha5, 0, t);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (acc_q.size() - acc_base !== 1 || acc_q[acc_base] !== 8'ha5) begin
      n_errors++; $display("FAIL glitch_next_byte: got %0d bytes want 1 of a5",
                           acc_q.size() - acc_base);
    end
    n_checks++;
    if (rise_q.size() <= rise_base || rise_q[rise_base] !== t + CommitOffset) begin
      n_errors++; $display("FAIL glitch_next_latency: want %0d after start", CommitOffset);
    end
  endtask

  task automatic test_framing();
    int t55;
    int t;
    int acc_base = acc_q.size();
    int fe_base = fe_cyc_q.size();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    data_out_ready = 1'b1;
    send_frame(8'h55, 2, t55);
    repeat (BitCycles) @(posedge clk);
    send_frame(8'h3e, 0, t);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (fe_cnt - fe0 !== 1) begin
      n_errors++; $display("FAIL framing_count: got %0d want 1", fe_cnt - fe0);
    end
    n_checks++;
    if (fe_cyc_q.size() <= fe_base || fe_cyc_q[fe_base] !== t55 + CommitOffset) begin
      n_errors++; $display("FAIL framing_timing: want pulse %0d after start", CommitOffset);
    end
    n_checks++;
    if (acc_q.size() - acc_base !== 1 || acc_q[acc_base] !== 8'h3e) begin
      n_errors++; $display("FAIL framing_next_byte: got %0d bytes want 1 of 3e",
                           acc_q.size() - acc_base);
    end
    n_checks++;
    if (ov_cnt - ov0 !== 0) begin
      n_errors++; $display("FAIL framing_overrun: got %0d want 0", ov_cnt - ov0);
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] a = 8'($urandom_range(0, 255));
    logic [7:0] b = 8'($urandom_range(0, 255));
    int t;
    int acc_base = acc_q.size();
    int ov0 = ov_cnt;
    data_out_ready = 1'b0;
    send_frame(a, 0, t);
    fork
      send_frame(b, 0, t);
      begin
        @(posedge clk);
        #1;
        repeat (CommitOffset - 1) @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ov_cnt - ov0 !== 0) begin
      n_errors++; $display("FAIL same_cycle_overrun: got %0d want 0", ov_cnt - ov0);
    end
    n_checks++;
    if (data_out_valid !== 1'b1 || data_out !== b) begin
      n_errors++; $display("FAIL same_cycle_buffer: got v=%b d=%h want v=1 d=%h",
                           data_out_valid, data_out, b);
    end
    n_checks++;
    if (acc_q.size() - acc_base !== 1 || acc_q[acc_base] !== a) begin
      n_errors++; $display("FAIL same_cycle_first: got %0d bytes want 1 of %h",
                           acc_q.size() - acc_base, a);
    end
    data_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] partial = 8'hca;
    int t;
    int acc_base;
    int fe0;
    data_out_ready = 1'b0;
    send_frame(8'h5a, 0, t);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (data_out_valid !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_preload: got valid %b want 1", data_out_valid);
    end
    @(posedge clk);
    #1;
    drive_bits(1'b0, 1);
    for (int i = 0; i < 4; i++) drive_bits(partial[i], 1);
    serial_in = partial[4];
    repeat (BitCycles / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    serial_in = 1'b1;
    #1;
    n_checks++;
    if (data_out !== 8'h00 || data_out_valid !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_outputs: got d=%h v=%b want 00 0", data_out, data_out_valid);
    end
    n_checks++;
    if (framing_error !== 1'b0 || overrun !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_pulses: got fe=%b ov=%b want 0 0", framing_error, overrun);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    acc_base = acc_q.size();
    fe0 = fe_cnt;
    data_out_ready = 1'b1;
    send_frame(8'h35, 0, t);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (acc_q.size() - acc_base !== 1 || acc_q[acc_base] !== 8'h35) begin
      n_errors++; $display("FAIL rstmid_next_byte: got %0d bytes want 1 of 35",
                           acc_q.size() - acc_base);
    end
    n_checks++;
    if (fe_cnt - fe0 !== 0) begin
      n_errors++; $display("FAIL rstmid_framing: got %0d want 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int n_bad = 0;
    int t;
    int acc_base = acc_q.size();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    data_out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [7:0] b = 8'($urandom_range(0, 255));
      bit bad = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 30)) @(posedge clk);
      send_frame(b, bad ? 1 : 0, t);
      if (bad) n_bad++;
      else exp_q.push_back(b);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (acc_q.size() - acc_base !== exp_q.size()) begin
      n_errors++; $display("FAIL random_count: got %0d want %0d",
                           acc_q.size() - acc_base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (acc_q[acc_base + k] !== exp_q[k]) begin
          n_errors++; $display("FAIL random_byte%0d: got %h want %h",
                               k, acc_q[acc_base + k], exp_q[k]);
        end
      end
    end
    n_checks++;
    if (fe_cnt - fe0 !== n_bad) begin
      n_errors++; $display("FAIL random_framing: got %0d want %0d", fe_cnt - fe0, n_bad);
    end
    n_checks++;
    if (ov_cnt - ov0 !== 0) begin
      n_errors++; $display("FAIL random_overrun: got %0d want 0", ov_cnt - ov0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_same_cycle();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_receiver.md
# uart_frame_receiver

Synthesizable 8N1 UART receiver. It is the on-chip end of the host→FPGA serial link (`serial_in`). It samples each bit at mid-period, checks the start and stop bits, and holds each received byte in a one-entry ready/valid output buffer for the CPU's memory-mapped UART. It reports framing errors and overruns as single-cycle pulses.

## Interface
- `CLOCK_FREQ`, default 125_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bit/s.
- `clk`  input  1: sole clock, rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `serial_in`  input  1: UART line; idles high.
- `data_out`  output  8: received byte, LSB is the first data bit on the line.
- `data_out_valid`  output  1: `data_out` holds an unconsumed byte.
- `data_out_ready`  input  1: consumer accepts the byte when `data_out_valid` and `data_out_ready` are both high on a rising edge.
- `framing_error`  output  1: one-cycle pulse when the stop bit is sampled low.
- `overrun`  output  1: one-cycle pulse when a good byte is dropped because the buffer is full.

## Operation
- Derived constants:
  - `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (integer division).
  - `SAMPLE_TIME = SYMBOL_EDGE_TIME / 2`.
  - Counter width is `$clog2(SYMBOL_EDGE_TIME)`.
  - Requirement: `SYMBOL_EDGE_TIME >= 4`.
- `rx` is the line as seen by the FSM: `serial_in` directly, or synchronized (see Configuration).
- FSM states and transitions:
  - IDLE: when `rx == 0`, go to START and clear the counter.
  - START: count to `SAMPLE_TIME-1`, then sample `rx`. If 0, go to DATA with the counter and bit index cleared. If 1, it was a glitch: go back to IDLE with no output.
  - DATA: every `SYMBOL_EDGE_TIME` cycles, sample `rx` into the shift register, LSB first. After the 8th sample, go to STOP.
  - STOP: after `SYMBOL_EDGE_TIME` cycles, sample `rx`.
    - If 1, commit the byte and go to IDLE.
    - If 0, pulse `framing_error`, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx == 1`, then go to IDLE. This prevents a break condition from being read as a start bit.
- Commit rules:
  - Buffer empty: load `data_out` and set `data_out_valid`.
  - Buffer full and accepted in the same cycle: load the new byte, `data_out_valid` stays 1.
  - Buffer full and not accepted: keep the old byte, drop the new one, pulse `overrun`.
- `data_out` is stable while `data_out_valid` is high and the byte is not accepted.
- A handshake with no commit in the same cycle clears `data_out_valid`.
- `data_out_ready` has no effect while `data_out_valid` is low.

## Timing
- Reset values: FSM in IDLE, counters 0, `data_out` = 8'h00, `data_out_valid` = 0, `framing_error` = 0, `overrun` = 0, synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame; any buffered byte is lost.
- After reset is released, a line that is still low is treated as a start edge.
- Latency: `data_out_valid` rises on the edge after the stop-bit sample. That edge is `SAMPLE_TIME + 9*SYMBOL_EDGE_TIME` cycles after `rx` first reads low, plus the synchronizer delay when it is enabled.
- `framing_error` and `overrun` assert on that same edge and last exactly one cycle.
- The earliest next start detection is the cycle after returning to IDLE, about half a bit before the nominal stop-bit end. This tolerates a transmitter running up to about 5% fast.

## Configuration
- Macro: `UART_RX_SYNC_EN`.
- Defined: `serial_in` passes through a two-flop synchronizer (reset to 1) before the FSM. All latencies grow by 2 cycles.
- Undefined: the FSM reads `serial_in` directly. This mode is only for benches that drive the line synchronously.

## Structure
- Shared package/header `uart_pkg`:
  - FSM state encoding: IDLE, START, DATA, STOP, WAIT_HIGH.
  - Frame constants: 8 data bits, 1 stop bit.
  - `SYMBOL_EDGE_TIME` / `SAMPLE_TIME` derivation helpers.
- One sub-module, `uart_rx_sync`, contains the two-flop synchronizer. It is instantiated only under `UART_RX_SYNC_EN`.
- FSM, counters, shift register and output buffer live in `uart_frame_receiver`.

## Test plan
All scenarios use `CLOCK_FREQ` = 50_000_000, `BAUD_RATE` = 1_000_000 (50 cycles/bit).
- Single byte: send 8'h61 with ready held high → one valid cycle with `data_out` = 8'h61; no error or overrun pulses.
- Back-to-back bytes: 8'h61, 8'h62, 8'h63 with ready held low, then ready pulsed → `data_out` stays 8'h61, `overrun` pulses twice; after the handshake valid drops.
- Glitch rejection: line low for 10 cycles, then high → no valid, no error, FSM back in IDLE.
- Framing error: 8'h55 with the stop bit low for 2 bits, then idle, then a clean 8'h3e → `framing_error` pulses once, no valid for 8'h55, next byte 8'h3e received.
- Accept and commit in the same cycle: hold the first byte until the exact commit edge of the second, then assert ready → no overrun, `data_out` = second byte, valid stays high.
- Reset mid-frame: assert `rst` during data bit 4 of 8'hca, release, send 8'h35 → only 8'h35 is delivered, and all outputs read reset values while in reset.
